// File: rtl/reg_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pipe_pkg
//  Brief    : Shared defaults and helpers for the reg_pipe register chain.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pipe_stage
//  Brief    : One pipeline stage: data flop bank with load enable plus a
//             valid bit; produces this stage's ready term for the chain.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             prev_v,
    input  logic [WIDTH-1:0] prev_d,
    input  logic             rdy_next,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;

    // Stage register: flush clears, load takes the predecessor; data only
    // moves when the predecessor is valid so an empty stage keeps its data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v <= 1'b0;
            r_d <= RESET_DATA;
        end else if (flush) begin
            r_v <= 1'b0;
            r_d <= RESET_DATA;
        end else if (load) begin
            r_v <= prev_v;
            if (prev_v) begin
                r_d <= prev_d;
            end
        end
    end

    // An empty stage can always take a word; a full one only if it can drain.
    assign rdy = !r_v || rdy_next;
    assign v   = r_v;
    assign d   = r_d;

endmodule
`default_nettype wire

// File: rtl/reg_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pipe
//  Brief    : DEPTH-stage elastic register pipeline with valid/ready on both
//             sides, bubble collapse, synchronous flush and an occupancy count.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter int               DEPTH      = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [count_width(DEPTH)-1:0]  count
);

    localparam int C_CW = count_width(DEPTH);

    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d      [DEPTH];
    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_rdy_next;
    logic [DEPTH-1:0] w_prev_v;
    logic [WIDTH-1:0] w_prev_d [DEPTH];
    logic             w_full_above;
    logic             w_push;
    logic             w_pop;
    logic [C_CW-1:0]  r_count;

    // Ready seen by each stage from its successor, written in closed form
    // (out_ready, or any empty stage further downstream) so the ready chain
    // depends only on the valid registers and never on itself.
    always_comb begin
        w_rdy_next   = '0;
        w_full_above = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            w_full_above = 1'b1;
            for (int j = i + 1; j < DEPTH; j++) begin
                w_full_above = w_full_above & w_v[j];
            end
            w_rdy_next[i] = out_ready | ~w_full_above;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign w_prev_v[gi] = in_valid;
            assign w_prev_d[gi] = in_data;
        end else begin : g_body
            assign w_prev_v[gi] = w_v[gi-1];
            assign w_prev_d[gi] = w_d[gi-1];
        end

        reg_pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .load     (w_rdy[gi]),
            .prev_v   (w_prev_v[gi]),
            .prev_d   (w_prev_d[gi]),
            .rdy_next (w_rdy_next[gi]),
            .v        (w_v[gi]),
            .d        (w_d[gi]),
            .rdy      (w_rdy[gi])
        );
    end

    // Input is refused during reset and during a flush cycle.
    assign in_ready  = w_rdy[0] & ~flush & reset;
    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready & ~flush;

    // Occupancy counter: tracks pushes minus pops, cleared by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + C_CW'(w_push) - C_CW'(w_pop);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_pipe
//  Brief    : Directed, scoreboarded bench for reg_pipe (WIDTH=8, DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;

    reg_pipe #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RESET_DATA (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               cyc;
    } ent_t;

    ent_t sb[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   m_cnt   = 0;
    int   cyc     = 0;
    int   peak    = 0;
    int   n_pops  = 0;
    bit   lat_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check handshake side against the model,
    // pop/compare on output handshake, then check the registered count.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id,
                        input logic ordy, input logic fl);
        logic exp_rdy;
        logic push;
        logic pop;
        ent_t e;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !fl && ((m_cnt < DEPTH) || ordy);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        push = iv && exp_rdy;
        pop  = out_valid && ordy;
        if (sb.size() == 0) begin
            chk("out_valid_when_empty", {31'd0, out_valid}, 32'd0);
        end else if (pop) begin
            e = sb.pop_front();
            chk("out_data", {24'd0, out_data}, {24'd0, e.d});
            if (lat_chk) chk("latency", cyc - e.cyc, DEPTH);
            n_pops++;
        end
        if (fl) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            if (push) sb.push_back('{d: id, cyc: cyc});
            m_cnt = m_cnt + int'(push) - int'(pop && !fl);
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("count", {29'd0, count}, m_cnt);
        if (m_cnt > peak) peak = m_cnt;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b0;

        // Reset held with input offered
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count",     {29'd0, count},     32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Stream at full rate, no stall
        lat_chk = 1'b1;
        peak    = 0;
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);
        lat_chk = 1'b0;
        chk("stream_peak",  peak,         32'd3);
        chk("stream_pops",  n_pops,       32'd3);
        chk("stream_empty", sb.size(),    32'd0);

        // Backpressure until full, then release
        for (int k = 0; k < 5; k++) step(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
        chk("full_count", {29'd0, count}, 32'd4);
        #1;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        n_pops = 0;
        step(1'b1, 8'hA4, 1'b1, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("release_no_gaps", n_pops, 32'd5);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Bubble collapse under out_ready=0
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bubble_not_yet", {31'd0, out_valid}, 32'd0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        chk("bubble_head_valid", {31'd0, out_valid}, 32'd1);
        chk("bubble_head_data",  {24'd0, out_data},  32'h55);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bubble_count", {29'd0, count}, 32'd2);
        n_pops = 0;
        repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bubble_packed", n_pops, 32'd2);

        // Full with simultaneous pop and push
        for (int k = 0; k < 4; k++) step(1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 8'hC0 + 8'(k), 1'b1, 1'b0);
        chk("popush_count", {29'd0, count}, 32'd4);
        repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Synchronous flush mid-stream
        for (int k = 0; k < 3; k++) step(1'b1, 8'hD0 + 8'(k), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("preflush_valid", {31'd0, out_valid}, 32'd1);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_out_data",  {24'd0, out_data},  32'd0);
        repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges
        for (int k = 0; k < 3; k++) step(1'b1, 8'hE0 + 8'(k), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("prereset_valid", {31'd0, out_valid}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("areset_count",     {29'd0, count},     32'd0);
        chk("areset_out_data",  {24'd0, out_data},  32'd0);
        chk("areset_in_ready",  {31'd0, in_ready},  32'd0);
        sb.delete();
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rerelease_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
